// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, colour type and constants for the quadrant renderer.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PIX_DIV  = 2;
    localparam int BORDER   = 4;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t COL_BLACK = rgb_t'(12'h000);
    localparam rgb_t COL_WHITE = rgb_t'(12'hFFF);
    localparam rgb_t COL_SEL   = rgb_t'(12'h0F0);
    localparam rgb_t COL_BG    = rgb_t'(12'h222);

    // Half-open window test [lo, hi) on plain integers to sidestep width juggling.
    function automatic logic in_window(input int val, input int lo, input int hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster timing: pixel-rate divider, h/v counters, active-low sync windows and
// the active-area flag, all decoded from the current counter values.
module vga_timing #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int PIX_DIV  = vga_pkg::PIX_DIV,
    parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic          o_tick,
    output logic [HW-1:0] o_h_cnt,
    output logic [VW-1:0] o_v_cnt,
    output logic          o_active,
    output logic          o_hsync_n,
    output logic          o_vsync_n
);
    import vga_pkg::*;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    logic [PW-1:0] r_pix_cnt;
    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          w_tick;
    logic          w_h_last;
    logic          w_v_last;

    // With PIX_DIV=1 the divider sits at zero and every clock is a tick.
    assign w_tick   = (r_pix_cnt == PW'(PIX_DIV - 1));
    assign w_h_last = (int'(r_h_cnt) == H_TOTAL - 1);
    assign w_v_last = (int'(r_v_cnt) == V_TOTAL - 1);

    // Pixel-rate divider
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pix_cnt <= '0;
        end else if (w_tick) begin
            r_pix_cnt <= '0;
        end else begin
            r_pix_cnt <= r_pix_cnt + PW'(1);
        end
    end

    // Raster position; the vertical counter steps when the line wraps
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_tick) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
            end else begin
                r_h_cnt <= r_h_cnt + HW'(1);
            end
        end
    end

    assign o_tick    = w_tick;
    assign o_h_cnt   = r_h_cnt;
    assign o_v_cnt   = r_v_cnt;
    assign o_active  = (int'(r_h_cnt) < H_ACTIVE) && (int'(r_v_cnt) < V_ACTIVE);
    assign o_hsync_n = !in_window(int'(r_h_cnt), H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC);
    assign o_vsync_n = !in_window(int'(r_v_cnt), V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC);

endmodule

// File: rtl/quadrant_vga_renderer.sv
// Draws a 2x2 grid with the player's square highlighted; the position is
// sampled once per frame at the start of vertical blank so moves never tear.
module quadrant_vga_renderer #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int PIX_DIV  = vga_pkg::PIX_DIV,
    parameter int BORDER   = vga_pkg::BORDER
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pos_x,
    input  logic       pos_y,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       frame_start
);
    import vga_pkg::*;

    localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

    logic          w_tick;
    logic          w_active;
    logic          w_hsync_n;
    logic          w_vsync_n;
    logic [HW-1:0] w_h_cnt;
    logic [VW-1:0] w_v_cnt;
    logic          w_latch;
    logic          w_qx;
    logic          w_qy;
    logic          w_grid;
    rgb_t          w_rgb;

    logic [1:0]    r_pos_q;
    logic          r_frame_start;
    logic          r_hsync;
    logic          r_vsync;
    rgb_t          r_rgb;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .PIX_DIV  (PIX_DIV),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .i_clk     (clk),
        .i_rst     (rst),
        .o_tick    (w_tick),
        .o_h_cnt   (w_h_cnt),
        .o_v_cnt   (w_v_cnt),
        .o_active  (w_active),
        .o_hsync_n (w_hsync_n),
        .o_vsync_n (w_vsync_n)
    );

    assign w_latch = w_tick && (w_h_cnt == '0) && (int'(w_v_cnt) == V_ACTIVE);
    assign w_qx    = (int'(w_h_cnt) >= H_ACTIVE / 2);
    assign w_qy    = (int'(w_v_cnt) < V_ACTIVE / 2);
    assign w_grid  = in_window(int'(w_h_cnt), H_ACTIVE / 2 - BORDER / 2, H_ACTIVE / 2 + BORDER / 2) ||
                     in_window(int'(w_v_cnt), V_ACTIVE / 2 - BORDER / 2, V_ACTIVE / 2 + BORDER / 2);

    // Position latch at start of vertical blank; frame_start lasts a single clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos_q       <= 2'b00;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_latch;
            if (w_latch) begin
                r_pos_q <= {pos_x, pos_y};
            end
        end
    end

    // Colour priority: blanking, grid line, selected square, background
    always_comb begin
        w_rgb = COL_BLACK;
        if (!w_active) begin
            w_rgb = COL_BLACK;
        end else if (w_grid) begin
            w_rgb = COL_WHITE;
        end else if ({w_qx, w_qy} == r_pos_q) begin
            w_rgb = COL_SEL;
        end else begin
            w_rgb = COL_BG;
        end
    end

    // Sync and colour share one register stage so they never skew
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= COL_BLACK;
        end else if (w_tick) begin
            r_hsync <= w_hsync_n;
            r_vsync <= w_vsync_n;
            r_rgb   <= w_rgb;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign red         = r_rgb.r;
    assign green       = r_rgb.g;
    assign blue        = r_rgb.b;
    assign frame_start = r_frame_start;

endmodule

// File: doc/quadrant_vga_renderer.md
# quadrant_vga_renderer

Renders the 2x2 player-position game state to a 640x480@60 Hz VGA display. Consumes the `pos_x`/`pos_y` square index produced by the game logic block and drives sync and 12-bit RGB to the board DAC. Generates VGA timing from the system clock through a pixel-rate divider. Latches the position once per frame so a move never tears the picture.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48: horizontal front porch, sync and back porch, in pixels.
- `V_ACTIVE`, 480: visible lines.
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33: vertical front porch, sync and back porch, in lines.
- `PIX_DIV`, 2: clock cycles per pixel (50 MHz clock gives 25 MHz pixels); must be at least 1.
- `BORDER`, 4: grid-line thickness in pixels (even).

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset. Asynchronous and active-high.
- `pos_x`, in, 1: player column. 0 = left, 1 = right.
- `pos_y`, in, 1: player row. 0 = lower, 1 = upper.
- `hsync`, out, 1: horizontal sync, active-low.
- `vsync`, out, 1: vertical sync, active-low.
- `red`, `green`, `blue`, out, 4 each: pixel colour.
- `frame_start`, out, 1: one-clock pulse on the cycle the position is latched.

## Operation
- **Pixel tick.** `pix_cnt` counts 0..PIX_DIV-1 and wraps. `tick` is asserted when `pix_cnt` == PIX_DIV-1. With PIX_DIV=1, `tick` is always 1.
- **Horizontal counter.** `h_cnt` counts 0..H_TOTAL-1 (H_TOTAL = 800) and advances on `tick`.
- **Vertical counter.** `v_cnt` counts 0..V_TOTAL-1 (V_TOTAL = 525). It advances on the `tick` where `h_cnt` wraps. Both counters wrap to 0 together at the end of the frame.
- **Sync windows.** `hsync` is low for `h_cnt` in [656,751]. `vsync` is low for `v_cnt` in [490,491].
- **Active region.** Active when `h_cnt` < H_ACTIVE and `v_cnt` < V_ACTIVE.
- **Position latch.** On the `tick` with `h_cnt`==0 and `v_cnt`==V_ACTIVE (start of vertical blank), `pos_q` <= {`pos_x`,`pos_y`} and `frame_start` pulses for that one clock. Input changes at any other time are ignored until the next latch.
- **Quadrant of the current pixel.** `qx` = (`h_cnt` >= 320). `qy` = (`v_cnt` < 240), so upper = 1, matching the game logic.
- **Colour priority**, highest first:
  - Blanking: 0x000.
  - Grid line, when `h_cnt` is in [320-BORDER/2, 320+BORDER/2) or `v_cnt` is in [240-BORDER/2, 240+BORDER/2): 0xFFF.
  - Selected quadrant ({`qx`,`qy`} == `pos_q`): 0x0F0.
  - Otherwise: 0x222.
- **Reset values.** `pix_cnt`, `h_cnt`, `v_cnt` = 0; `pos_q` = 2'b00 (lower-left); `hsync` = `vsync` = 1; RGB = 0; `frame_start` = 0.

## Timing
- All outputs are registered and update only on `tick` clocks. Exception: `frame_start` deasserts on the next clock.
- Latency: `hsync`, `vsync` and RGB for counter value (h,v) appear together one clock after the `tick` at which the counters hold (h,v). Sync and colour never skew against each other.
- Frame period: 800 x 525 x PIX_DIV clocks, which is 840000 at PIX_DIV=2. `frame_start` period is identical.
- If `pos_x`/`pos_y` change on the latch clock edge, the value sampled at that edge is used.
- Reset asserted mid-frame: all outputs take reset values immediately, asynchronously. After release, counting restarts at h=0, v=0. The first `tick` occurs PIX_DIV clocks after the first active edge.
- A position update becomes visible starting with the first active pixel of the next frame. It never appears mid-frame.

## Structure
- Package `vga_pkg` holds:
  - Timing constants (H_ACTIVE..V_BP, H_TOTAL, V_TOTAL).
  - `typedef struct packed {logic [3:0] r, g, b;} rgb_t`.
  - Colour constants `COL_BLACK`, `COL_WHITE`, `COL_SEL`, `COL_BG`.
- Sub-module `vga_timing` owns the pixel divider, the counters, sync generation and the active flag, and exports `h_cnt`, `v_cnt`, `active` and `tick`.
- `quadrant_vga_renderer` owns the position latch, quadrant decode, colour mux and output registers.

## Test plan
- **Sync timing.** Reset, then run 2 frames with PIX_DIV=2. Required: `hsync` low for 192 clocks every 1600 clocks; `vsync` low for 3200 clocks every 840000 clocks; `frame_start` pulses exactly twice, 840000 clocks apart.
- **Quadrant colour.** Hold `pos_x`=1, `pos_y`=1 across a latch. In the next frame, pixel (500,100) = 0x0F0, pixel (100,100) = 0x222, pixel (319,50) = 0xFFF, and any pixel with `h_cnt` >= 640 = 0x000.
- **Mid-frame input change.** Change input 00 -> 10 at line 100. Required: the rest of that frame still highlights lower-left; the next frame highlights lower-right.
- **Change at the latch edge.** Toggle the position on the exact latch edge. Required: the new value is latched, and `frame_start` = 1 on that clock.
- **Reset mid-frame.** Assert `rst` mid-frame at line 300. Required: `hsync`/`vsync` = 1 and RGB = 0 within the same cycle; after release, the first `hsync` falling edge comes 656 ticks later; `pos_q` shows lower-left.
- **PIX_DIV=1.** Run with PIX_DIV=1. Required: line period is 800 clocks and frame period is 420000 clocks.
